// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : shift_seq_pkg
// Purpose : Operation encodings, sequencer states and step size for shift_seq.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
package shift_seq_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;

  localparam int NIB_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NIB  = 2'd1,
    BIT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  function automatic logic op_valid(input logic [2:0] o);
    return (o <= OP_SRL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : shifter_4
// Purpose : One NIB_BITS-wide shift/rotate step on a 16-bit word when sh=1.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module shifter_4
  import shift_seq_pkg::*;
(
  input  logic [15:0] din,
  input  logic [2:0]  op,
  input  logic        sh,
  output logic [15:0] dout
);

  always_comb begin
    dout = din;
    if (sh) begin
      case (op)
        OP_ROL:  dout = {din[15-NIB_BITS:0], din[15:16-NIB_BITS]};
        OP_ROR:  dout = {din[NIB_BITS-1:0], din[15:NIB_BITS]};
        OP_SLL:  dout = {din[15-NIB_BITS:0], {NIB_BITS{1'b0}}};
        OP_SRA:  dout = {{NIB_BITS{din[15]}}, din[15:NIB_BITS]};
        OP_SRL:  dout = {{NIB_BITS{1'b0}}, din[15:NIB_BITS]};
        default: dout = din;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : shift_seq
// Purpose : Multi-cycle 16-bit shift/rotate sequencer: nibble steps through
//           shifter_4, then single-bit steps when SHIFT_SEQ_FINE_EN is defined.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module shift_seq
  import shift_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [2:0]  op,
  input  logic [3:0]  amt,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic        err
);

`ifdef SHIFT_SEQ_FINE_EN
  localparam logic [1:0] c_bit_mask = 2'b11;
`else
  localparam logic [1:0] c_bit_mask = 2'b00;
`endif

  state_t      r_state;
  logic [15:0] r_acc;
  logic [2:0]  r_op;
  logic [1:0]  r_nib_cnt;
  logic [1:0]  r_bit_cnt;
  logic [15:0] w_nib;
  logic [1:0]  w_bit_amt;

  // Without the fine stage the low amount bits are forced to zero here.
  assign w_bit_amt = amt[1:0] & c_bit_mask;

  shifter_4 u_shifter_4 (
    .din  (r_acc),
    .op   (r_op),
    .sh   (1'b1),
    .dout (w_nib)
  );

`ifdef SHIFT_SEQ_FINE_EN
  logic [15:0] w_bit;

  always_comb begin
    w_bit = r_acc;
    case (r_op)
      OP_ROL:  w_bit = {r_acc[14:0], r_acc[15]};
      OP_ROR:  w_bit = {r_acc[0], r_acc[15:1]};
      OP_SLL:  w_bit = {r_acc[14:0], 1'b0};
      OP_SRA:  w_bit = {r_acc[15], r_acc[15:1]};
      OP_SRL:  w_bit = {1'b0, r_acc[15:1]};
      default: w_bit = r_acc;
    endcase
  end
`endif

  // done/err/out are registered on the edge that enters FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= 16'h0000;
      r_op      <= OP_ROL;
      r_nib_cnt <= 2'd0;
      r_bit_cnt <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out       <= 16'h0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE, FIN: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          if (start) begin
            r_acc     <= in;
            r_op      <= op;
            r_nib_cnt <= amt[3:2];
            r_bit_cnt <= w_bit_amt;
            if (!op_valid(op)) begin
              r_state <= FIN;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (amt[3:2] != 2'd0) begin
              r_state <= NIB;
              busy    <= 1'b1;
            end else if (w_bit_amt != 2'd0) begin
              r_state <= BIT;
              busy    <= 1'b1;
            end else begin
              r_state <= FIN;
              done    <= 1'b1;
              out     <= in;
            end
          end
        end

        NIB: begin
          r_acc     <= w_nib;
          r_nib_cnt <= r_nib_cnt - 2'd1;
          if (r_nib_cnt == 2'd1) begin
            if (r_bit_cnt != 2'd0) begin
              r_state <= BIT;
            end else begin
              r_state <= FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              out     <= w_nib;
            end
          end
        end

`ifdef SHIFT_SEQ_FINE_EN
        BIT: begin
          r_acc     <= w_bit;
          r_bit_cnt <= r_bit_cnt - 2'd1;
          if (r_bit_cnt == 2'd1) begin
            r_state <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            out     <= w_bit;
          end
        end
`endif

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_shift_seq
// Purpose : Self-checking bench for shift_seq (honours SHIFT_SEQ_FINE_EN).
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_shift_seq;

`ifdef SHIFT_SEQ_FINE_EN
  localparam bit FINE = 1'b1;
`else
  localparam bit FINE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in = 16'h0000;
  logic [2:0]  op = 3'd0;
  logic [3:0]  amt = 4'd0;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_out = 16'h0000;
  bit          pending = 1'b0;

  shift_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .op    (op),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: rotate via a doubled word, shifts via native operators.
  function automatic logic [15:0] ref_shift(input logic [2:0] o, input logic [15:0] x,
                                            input logic [3:0] a);
    int                 n;
    logic        [31:0] d;
    logic signed [15:0] sx;
    n  = FINE ? int'(a) : int'(a & 4'hC);
    d  = {x, x};
    sx = x;
    case (o)
      3'd0: begin d = d << n; return d[31:16]; end
      3'd1: begin d = d >> n; return d[15:0]; end
      3'd2: return x << n;
      3'd3: return sx >>> n;
      3'd4: return x >> n;
      default: return x;
    endcase
  endfunction

  function automatic int ref_steps(input logic [2:0] o, input logic [3:0] a);
    if (o > 3'd4) return 0;
    return FINE ? int'(a[3:2]) + int'(a[1:0]) : int'(a[3:2]);
  endfunction

  task automatic do_req(input logic [2:0] q_op, input logic [15:0] q_in, input logic [3:0] q_amt,
                        input bit b2b, input logic [2:0] n_op, input logic [15:0] n_in,
                        input logic [3:0] n_amt);
    int          s;
    logic        valid;
    logic [15:0] exp_out;
    valid   = (q_op <= 3'd4);
    s       = ref_steps(q_op, q_amt);
    exp_out = valid ? ref_shift(q_op, q_in, q_amt) : model_out;
    if (!pending) begin
      @(negedge clk);
      start = 1'b1; op = q_op; in = q_in; amt = q_amt;
    end
    pending = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= s + 1; k++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(k <= s));
      check("done", 32'(done), 32'(k == s + 1));
      check("err",  32'(err),  32'((k == s + 1) && !valid));
      check("out",  32'(out),  32'((k == s + 1) ? exp_out : model_out));
      if (k <= s) begin
        // Junk requests while busy must be ignored.
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom);
        in    = 16'($urandom);
        amt   = 4'($urandom);
      end else if (b2b) begin
        start = 1'b1; op = n_op; in = n_in; amt = n_amt;
        pending = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    model_out = exp_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      in    = 16'($urandom);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_out",  32'(out),  32'(model_out));
    end
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    start = 1'b1; op = 3'd4; in = 16'h8000; amt = 4'd15;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("rst_pre_busy", 32'(busy), 32'd1);
      check("rst_pre_done", 32'(done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_out",  32'(out),  32'h0000);
    rst = 1'b0;
    model_out = 16'h0000;
    idle(10);
  endtask

  logic [2:0]  r_ops [0:40];
  logic [15:0] r_ins [0:40];
  logic [3:0]  r_amts[0:40];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err",  32'(err),  32'd0);
    check("reset_out",  32'(out),  32'h0000);
    idle(2);

    do_req(3'd0, 16'h1234, 4'd4, 1'b0, 3'd0, 16'h0, 4'd0);
    check("tp_rol", 32'(out), 32'h2341);
    do_req(3'd3, 16'h8000, 4'd7, 1'b0, 3'd0, 16'h0, 4'd0);
    check("tp_sra", 32'(out), FINE ? 32'hFF00 : 32'hF800);
    do_req(3'd4, 16'h8000, 4'd15, 1'b0, 3'd0, 16'h0, 4'd0);
    check("tp_srl", 32'(out), FINE ? 32'h0001 : 32'h0008);
    idle(1);
    do_req(3'd1, 16'h0001, 4'd0, 1'b1, 3'd2, 16'h0001, 4'd1);
    check("tp_ror0", 32'(out), 32'h0001);
    do_req(3'd2, 16'h0001, 4'd1, 1'b0, 3'd0, 16'h0, 4'd0);
    check("tp_sll_b2b", 32'(out), FINE ? 32'h0002 : 32'h0001);
    do_req(3'd5, 16'hABCD, 4'd3, 1'b0, 3'd0, 16'h0, 4'd0);
    check("tp_inv_hold", 32'(out), FINE ? 32'h0002 : 32'h0001);
    idle(2);

    reset_mid_op();
    do_req(3'd0, 16'h00F0, 4'd5, 1'b0, 3'd0, 16'h0, 4'd0);

    for (int i = 0; i <= 40; i++) begin
      r_ops[i]  = ($urandom_range(0, 9) == 0) ? 3'(5 + $urandom_range(0, 2))
                                              : 3'($urandom_range(0, 4));
      r_ins[i]  = 16'($urandom);
      r_amts[i] = 4'($urandom);
    end
    for (int i = 0; i < 40; i++) begin
      bit b2b;
      b2b = ($urandom_range(0, 2) == 0);
      do_req(r_ops[i], r_ins[i], r_amts[i], b2b, r_ops[i+1], r_ins[i+1], r_amts[i+1]);
      if (!b2b) idle(int'($urandom_range(0, 2)));
    end
    do_req(r_ops[40], r_ins[40], r_amts[40], 1'b0, 3'd0, 16'h0, 4'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer sitting in front of the existing 4-bit-step shifter (`shifter_4`) in the execute stage. It accepts one 16-bit shift/rotate request with a bit amount of 0..15. It realises the request as a sequence of nibble steps through `shifter_4`, followed by single-bit steps in a local 1-bit stage. It reports completion with a one-cycle `done` pulse and holds the result until the next request completes.

## Interface
- No parameters; data width is fixed at 16 to match the datapath.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `in`  in  16  operand, captured on an accepted `start`.
- `op`  in  3  operation, captured with `in`.
  - 000: rotate left (ROL).
  - 001: rotate right (ROR).
  - 010: shift left logical (SLL).
  - 011: shift right arithmetic (SRA).
  - 100: shift right logical (SRL).
  - 101..111: invalid.
- `amt`  in  4  shift amount in bits, captured with `in`.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse; `out`/`err` valid in that cycle.
- `out`  out  16  result register; held between operations.
- `err`  out  1  one-cycle pulse coincident with `done` for an invalid `op`.

## Operation
- States:
  - IDLE
  - NIB: nibble steps.
  - BIT: single-bit steps.
  - FIN: issue `done`.
- IDLE:
  - `start`=1 captures `in` into accumulator `acc`, plus `op`, `nib_cnt`=`amt[3:2]` and `bit_cnt`=`amt[1:0]`; sets `busy`.
  - Next state is NIB if `nib_cnt`≠0, else BIT if `bit_cnt`≠0, else FIN.
  - An invalid `op` goes to FIN directly with an error flag latched.
- NIB:
  - Each cycle `acc` ← `shifter_4`(`acc`, `op`, sh=1) and `nib_cnt` decrements.
  - On the last step, go to BIT if `bit_cnt`≠0, else FIN.
- BIT:
  - Each cycle `acc` shifts by one position per `op`.
  - SLL fills with 0, SRL fills with 0, SRA replicates bit 15, ROL/ROR wrap around.
  - `bit_cnt` decrements; on the last step go to FIN.
- FIN:
  - `done`=1, `busy`=0 and the state returns to IDLE.
  - `out` ← `acc`, except when the error flag is set: then `err`=1 and `out` keeps its old value.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` in the FIN cycle is accepted, so back-to-back operation is allowed.
- `amt`=0 with a valid `op` returns `in` unchanged.
- Reset values: `busy`=0, `done`=0, `err`=0, `out`=16'h0000; state IDLE; counters 0.
- Reset mid-operation aborts the request with no `done` pulse, and all outputs return to their reset values on the next edge.

## Timing
- Accept edge T, where `start` is sampled high in IDLE or FIN.
- Steps S = `amt[3:2]` + `amt[1:0]`, range 0..6.
- `done` is high during cycle T+1+S. Latency ranges from 1 cycle (`amt`=0) to 7 cycles (`amt`=15).
- An invalid `op` gives `done` and `err` at T+1.
- `busy` is high in cycles T+1 .. T+S and low in the FIN cycle.
- `out` changes only on the FIN edge and is stable otherwise.

## Configuration
- `SHIFT_SEQ_FINE_EN` defined:
  - The BIT state and 1-bit stage are built.
  - All amounts 0..15 are exact.
- `SHIFT_SEQ_FINE_EN` undefined:
  - BIT state and 1-bit stage are omitted; `amt[1:0]` is ignored (treated as 0).
  - Only multiples of 4 are honoured, so S = `amt[3:2]`.

## Structure
- Package `shift_seq_pkg` holds:
  - the `op` encodings (OP_ROL..OP_SRL);
  - the state enum {IDLE, NIB, BIT, FIN};
  - the constant NIB_BITS=4.
- One sub-module: `shifter_4`, instantiated once with `sh` tied to 1 and driven from `acc`. Its output is used only in NIB.
- The 1-bit stage is inline combinational logic, not a separate module.

## Test plan
- ROL, `in`=16'h1234, `amt`=4: `done` at T+2, `out`=16'h2341, `err`=0.
- SRA, `in`=16'h8000, `amt`=7:
  - with `SHIFT_SEQ_FINE_EN`: `done` at T+5, `out`=16'hFF00;
  - without it: `done` at T+2, `out`=16'hF800.
- SRL, `in`=16'h8000, `amt`=15 (FINE_EN): `done` at T+7, `out`=16'h0001. A second `start` at T+3 is ignored, and `busy` is high T+1..T+6.
- ROR, `in`=16'h0001, `amt`=0: `done` at T+1, `out`=16'h0001. A `start` in that FIN cycle with SLL, 16'h0001, `amt`=1 gives `done` at T+3 and `out`=16'h0002.
- `op`=101, `in`=16'hABCD, previous `out`=16'h0002: `done`=`err`=1 at T+1, and `out` stays 16'h0002.
- SRL, `amt`=15 started, `rst`=1 in cycle T+3:
  - next edge gives `busy`=0, `out`=16'h0000, and no `done` is ever issued;
  - a new request afterwards completes normally.
